// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the
// per-op mask that selects which of result/N/Z/C/V a completed op writes.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_OR  = 4'd0,
        OP_AND = 4'd1,
        OP_EOR = 4'd2,
        OP_ADC = 4'd3,
        OP_SHL = 4'd4,
        OP_SHR = 4'd5,
        OP_CMP = 4'd6,
        OP_SBC = 4'd7,
        OP_BIT = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } alu_state_t;

    typedef struct packed {
        logic res;
        logic n;
        logic z;
        logic c;
        logic v;
    } upd_mask_t;

    localparam upd_mask_t MASK_LOGIC = '{res: 1'b1, n: 1'b1, z: 1'b1, c: 1'b0, v: 1'b0};
    localparam upd_mask_t MASK_ARITH = '{res: 1'b1, n: 1'b1, z: 1'b1, c: 1'b1, v: 1'b1};
    localparam upd_mask_t MASK_NZC   = '{res: 1'b1, n: 1'b1, z: 1'b1, c: 1'b1, v: 1'b0};
    localparam upd_mask_t MASK_BIT   = '{res: 1'b1, n: 1'b1, z: 1'b1, c: 1'b0, v: 1'b1};
    localparam upd_mask_t MASK_NONE  = '{res: 1'b0, n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b0};

    // Unknown op codes write nothing, so the previous result and flags stay.
    function automatic upd_mask_t op_mask(input logic [3:0] op);
        upd_mask_t m;
        case (op)
            OP_OR, OP_AND, OP_EOR:  m = MASK_LOGIC;
            OP_ADC, OP_SBC:         m = MASK_ARITH;
            OP_CMP, OP_SHL, OP_SHR: m = MASK_NZC;
            OP_BIT:                 m = MASK_BIT;
            default:                m = MASK_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control sequencer (master) and the ALU (slave).
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             d_flag;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             z_out;
    logic             v_out;
    logic             n_out;

    modport master (
        output start, op, a, b, c_in, d_flag,
        input  busy, done, result, c_out, z_out, v_out, n_out
    );

    modport slave (
        input  start, op, a, b, c_in, d_flag,
        output busy, done, result, c_out, z_out, v_out, n_out
    );
endinterface

// File: rtl/bcd_nibble_adder.sv
// One BCD digit of decimal add/subtract. c_in/c_out are carry for add and
// not-borrow for subtract, so the same register chains both directions.
module bcd_nibble_adder (
    input  logic [3:0] an,
    input  logic [3:0] bn,
    input  logic       c_in,
    input  logic       sub,
    output logic [3:0] s,
    output logic       c_out
);
    logic [4:0] sum;
    logic [4:0] diff;

    // Binary nibble sum/difference followed by the +6 / -6 decimal correction.
    always_comb begin
        sum   = {1'b0, an} + {1'b0, bn} + {4'b0000, c_in};
        diff  = {1'b0, an} - {1'b0, bn} - {4'b0000, ~c_in};
        s     = sum[3:0];
        c_out = 1'b0;
        if (sub) begin
            if (diff[4]) begin
                s     = diff[3:0] - 4'd6;
                c_out = 1'b0;
            end else begin
                s     = diff[3:0];
                c_out = 1'b1;
            end
        end else if (sum > 5'd9) begin
            s     = sum[3:0] + 4'd6;
            c_out = 1'b1;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Sequential 6502 ALU. Binary ops finish in one cycle straight from the
// bus operands; decimal ADC/SBC run one BCD digit per cycle, LSB first.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start
// EXEC    | decimal op in flight, one nibble per cycle (busy=1)
// DONE    | done pulse; result/flags just written; may accept start
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int MSB = WIDTH - 1;

    alu_state_t       state;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;
    logic             c_q, z_q, v_q, n_q;

    logic [WIDTH-1:0] a_q, b_q, acc_q;
    logic             carry_q, sub_q, v_dec_q;
    logic [CW-1:0]    nib_cnt;
    logic [CW-1:0]    nib_idx;

    logic [WIDTH:0]   sum_add, sum_sub, sum_cmp;
    logic             v_add, v_sub;
    logic [WIDTH-1:0] bin_res;
    logic             bin_c, bin_v, bin_n, bin_z;
    upd_mask_t        mask;
    logic             dec_op;

    logic [3:0]       nib_a, nib_b, nib_s;
    logic             nib_c;
    logic [WIDTH-1:0] dec_res;

    assign sum_add = {1'b0, bus.a} + {1'b0, bus.b}  + {{WIDTH{1'b0}}, bus.c_in};
    assign sum_sub = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, bus.c_in};
    assign sum_cmp = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    assign v_add   = (bus.a[MSB] ~^ bus.b[MSB]) & (bus.a[MSB] ^ sum_add[MSB]);
    assign v_sub   = (bus.a[MSB] ^  bus.b[MSB]) & (bus.a[MSB] ^ sum_sub[MSB]);
    assign mask    = op_mask(bus.op);
    assign dec_op  = DECIMAL_EN && bus.d_flag && (bus.op == OP_ADC || bus.op == OP_SBC);

    // Single-cycle result and flag candidates, computed from the live bus operands.
    always_comb begin
        bin_res = bus.a;
        bin_c   = 1'b0;
        bin_v   = 1'b0;
        case (bus.op)
            OP_OR:  bin_res = bus.a | bus.b;
            OP_AND: bin_res = bus.a & bus.b;
            OP_EOR: bin_res = bus.a ^ bus.b;
            OP_ADC: begin
                bin_res = sum_add[WIDTH-1:0];
                bin_c   = sum_add[WIDTH];
                bin_v   = v_add;
            end
            OP_SBC: begin
                bin_res = sum_sub[WIDTH-1:0];
                bin_c   = sum_sub[WIDTH];
                bin_v   = v_sub;
            end
            OP_CMP: begin
                bin_res = sum_cmp[WIDTH-1:0];
                bin_c   = sum_cmp[WIDTH];
            end
            OP_SHL: {bin_c, bin_res} = {bus.a, bus.c_in};
            OP_SHR: {bin_res, bin_c} = {bus.c_in, bus.a};
            OP_BIT: begin
                bin_res = bus.a;
                bin_v   = bus.b[WIDTH-2];
            end
            default: ;
        endcase
        bin_n = (bus.op == OP_BIT) ? bus.b[MSB] : bin_res[MSB];
        bin_z = (bus.op == OP_BIT) ? ~|(bus.a & bus.b) : ~|bin_res;
    end

    // Remaining-nibble count runs down; the digit position is its complement.
    assign nib_idx = CW'(NIB - 1) - nib_cnt;
    assign nib_a   = a_q[{nib_idx, 2'b00} +: 4];
    assign nib_b   = b_q[{nib_idx, 2'b00} +: 4];

    // Accumulated BCD result with the current digit already merged in.
    always_comb begin
        dec_res = acc_q;
        dec_res[{nib_idx, 2'b00} +: 4] = nib_s;
    end

    generate
        if (DECIMAL_EN) begin : g_bcd
            bcd_nibble_adder u_bcd (
                .an    (nib_a),
                .bn    (nib_b),
                .c_in  (carry_q),
                .sub   (sub_q),
                .s     (nib_s),
                .c_out (nib_c)
            );
        end else begin : g_no_bcd
            assign nib_s = 4'h0;
            assign nib_c = 1'b0;
        end
    endgenerate

    // Control FSM with registered done/busy/result/flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            v_q      <= 1'b0;
            n_q      <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            sub_q    <= 1'b0;
            v_dec_q  <= 1'b0;
            nib_cnt  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_EXEC: begin
                    acc_q   <= dec_res;
                    carry_q <= nib_c;
                    if (nib_cnt == '0) begin
                        state    <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        result_q <= dec_res;
                        c_q      <= nib_c;
                        v_q      <= v_dec_q;
                        n_q      <= dec_res[MSB];
                        z_q      <= ~|dec_res;
                    end else begin
                        nib_cnt <= nib_cnt - 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                    state <= ST_IDLE;
                    if (bus.start) begin
                        if (dec_op) begin
                            state   <= ST_EXEC;
                            busy_q  <= 1'b1;
                            a_q     <= bus.a;
                            b_q     <= bus.b;
                            acc_q   <= '0;
                            carry_q <= bus.c_in;
                            sub_q   <= (bus.op == OP_SBC);
                            v_dec_q <= (bus.op == OP_SBC) ? v_sub : v_add;
                            nib_cnt <= CW'(NIB - 1);
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            if (mask.res) result_q <= bin_res;
                            if (mask.n)   n_q      <= bin_n;
                            if (mask.z)   z_q      <= bin_z;
                            if (mask.c)   c_q      <= bin_c;
                            if (mask.v)   v_q      <= bin_v;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.c_out  = c_q;
    assign bus.z_out  = z_q;
    assign bus.v_out  = v_q;
    assign bus.n_out  = n_q;
endmodule
